y_if_prefetch: RTL
==================

// Module: y_if_prefetch
// PURPOSE
//  Parametrised successor of the single-register instruction-fetch stage. Holds the fetch PC and
//  issues pipelined requests to an in-order instruction memory. Buffers returned words with their
//  PC in a DEPTH-entry queue feeding decode via valid/ready. Redirects (branch/jump) flush the
//  queue and squash responses still in flight.
// PARAMETERS
//  WIDTH     32         address and instruction width, bits (>=8)
//  DEPTH     4          queue entries and max requests in flight; power of 2, >=2
//  RESET_PC  {WIDTH{0}} fetch PC loaded on reset
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  imem_req     out  1      request valid
//  imem_addr    out  WIDTH  request address (= fetch PC)
//  imem_ready   in   1      memory accepts request this cycle
//  imem_rvalid  in   1      response valid; one per accepted request, in order, no backpressure
//  imem_rdata   in   WIDTH  response instruction word
//  ins_valid    out  1      queue head valid
//  ins          out  WIDTH  head instruction
//  ins_pc       out  WIDTH  PC of head instruction
//  ins_pcp4     out  WIDTH  ins_pc + 4, modulo 2^WIDTH
//  ins_ready    in   1      decode consumes head
//  redirect     in   1      one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc  in   WIDTH  new fetch PC
//  align_err    out  1      sticky misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): fetch_pc=resp_pc=RESET_PC; queue empty; inflight=discard=0; align_err=0;
//    imem_req=0, ins_valid=0. ins/ins_pc hold last value (don't-care while ins_valid=0).
//  - inflight: accepted requests not yet answered (incl. those being discarded).
//  - imem_req = rst_n & !redirect & !align_err & (inflight + count < DEPTH); combinational.
//  - Accept = imem_req & imem_ready: fetch_pc += 4 (wraps mod 2^WIDTH); inflight++.
//  - Response: if discard>0, word dropped, discard--; else push {imem_rdata, resp_pc}, resp_pc += 4.
//    inflight-- in both cases. Response with inflight==0 ignored (post-reset stragglers).
//  - Pushed word appears at ins_valid the next cycle. Minimum latency imem_req accepted at cycle
//    N, rvalid at N+1 -> ins_valid at N+2. Back-to-back: one instruction per cycle sustained.
//  - Pop = ins_valid & ins_ready. Push+pop same cycle: count unchanged, FIFO order kept.
//  - Full: credit rule guarantees a push never hits a full queue; no overflow path needed.
//  - ins_valid = (count != 0) & !redirect.
//  - Redirect (highest priority, same edge): queue flushed (count=0, pop void),
//    fetch_pc = resp_pc = redirect_pc, discard = inflight - imem_rvalid (response that edge is
//    dropped); no request issued in redirect cycle. Back-to-back redirects: last one wins, discard
//    recomputed each time. In-flight squashed requests still consume credits until returned.
//  - Reset mid-operation clears everything immediately; memory must be reset concurrently.
// CONFIGURATION
//  YIF_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets align_err (sticky), still
//    flushes queue and sets discard; imem_req held low until an aligned redirect (clears
//    align_err) or reset. RESET_PC must be aligned.
//  Not defined: redirect_pc[1:0] forced to 2'b00 on load; align_err tied 0.
// TESTING
//  1 Reset, RESET_PC=0x100, imem 1-cycle latency, ins_ready=1 -> ins_pc 0x100,0x104,0x108...
//    one per cycle, first ins_valid 2 cycles after rst_n rises, ins_pcp4=ins_pc+4.
//  2 ins_ready=0 for 10 cycles -> exactly DEPTH=4 requests accepted, then imem_req=0; release
//    -> 4 entries drain in order, fetching resumes, no word lost or duplicated.
//  3 imem 3-cycle latency, redirect to 0x200 with 2 in flight -> both stale words dropped,
//    next ins_valid shows ins_pc=0x200 with data from 0x200.
//  4 redirect on same cycle as imem_rvalid and ins_ready=1 with queue non-empty -> no pop seen,
//    queue empty next cycle, stale response dropped, discard = inflight-1.
//  5 fetch_pc=0xFFFF_FFFC (WIDTH=32) -> next imem_addr 0x0000_0000; ins_pcp4 of last word = 0.
//  6 YIF_ALIGN_CHECK_EN: redirect to 0x202 -> align_err=1, imem_req=0; redirect 0x300 -> cleared,
//    fetch resumes at 0x300. Undefined: redirect 0x202 -> fetch at 0x200, align_err=0.

Source files
------------

// File: rtl/y_if_prefetch.sv
// y_if_prefetch: instruction-fetch stage with a DEPTH-deep queue of {word, pc} to decode.
// Requests are credit-limited so that inflight + queued never exceeds DEPTH. A redirect
// flushes the queue and marks every outstanding response as stale so that it is dropped.
// Optional feature macro: YIF_ALIGN_CHECK_EN (sticky align_err on misaligned redirects).
module y_if_prefetch #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             ins_valid,
    output logic [WIDTH-1:0] ins,
    output logic [WIDTH-1:0] ins_pc,
    output logic [WIDTH-1:0] ins_pcp4,
    input  logic             ins_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             align_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] fetch_pc, resp_pc, load_pc;
    logic [CW-1:0]    count, inflight, discard;
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [WIDTH-1:0] q_ins [DEPTH];
    logic [WIDTH-1:0] q_pc  [DEPTH];
    logic [CW:0]      credits_used;
    logic             accept, resp, drop, push, pop;

    // Credits cover both queued words and words still owed by memory, stale ones included,
    // which is what keeps a push from ever landing on a full queue.
    assign credits_used = {1'b0, inflight} + {1'b0, count};
    assign imem_req     = rst_n & ~redirect & ~align_err & (credits_used < (CW+1)'(DEPTH));
    assign imem_addr    = fetch_pc;
    assign accept       = imem_req & imem_ready;
    // Responses arriving with nothing outstanding are leftovers from before a reset.
    assign resp         = imem_rvalid & (inflight != '0);
    assign drop         = resp & (discard != '0);
    assign push         = resp & ~drop & ~redirect;
    assign ins_valid    = (count != '0) & ~redirect;
    assign pop          = ins_valid & ins_ready;
    assign ins          = q_ins[rd_ptr];
    assign ins_pc       = q_pc[rd_ptr];
    assign ins_pcp4     = ins_pc + WIDTH'(4);

`ifdef YIF_ALIGN_CHECK_EN
    logic align_err_q;
    assign load_pc   = redirect_pc;
    assign align_err = align_err_q;

    // Sticky flag: set by a misaligned redirect, cleared only by an aligned one or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            align_err_q <= 1'b0;
        else if (redirect)
            align_err_q <= (redirect_pc[1:0] != 2'b00);
    end
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign load_pc    = {redirect_pc[WIDTH-1:2], 2'b00};
    assign align_err  = 1'b0;
`endif

    // Fetch/response PCs, occupancy, in-flight and stale-response bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(resp);
            if (redirect) begin
                // Everything still owed by memory after this edge is stale.
                fetch_pc <= load_pc;
                resp_pc  <= load_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= inflight - CW'(resp);
            end else begin
                if (accept) fetch_pc <= fetch_pc + WIDTH'(4);
                if (push) begin
                    resp_pc <= resp_pc + WIDTH'(4);
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop)  rd_ptr  <= rd_ptr + AW'(1);
                if (drop) discard <= discard - CW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_ins[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]  <= resp_pc;
        end
    end
endmodule
